// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles every bus signal around the memory port arbiter: the instruction
// fetch requester (if_*), the data access requester (dm_*), the shared memory
// handshake (mem_*) and the arbiter status flags (err, busy).
//
// Modports
//   slave  : the arbiter's view (requests and memory ack in, grants/data out)
//   master : the surrounding system's view (core requesters plus memory)
//
// Signals
//   if_req/if_addr               fetch request, held until if_done
//   if_rdata/if_done             fetch data and one-cycle completion pulse
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_wstrb            data request, held until dm_done
//   dm_rdata/dm_done             data read value and one-cycle completion pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_wstrb          memory request, held until ack or timeout
//   mem_ack/mem_rdata            memory completion and read data
//   err                          timeout pulse, coincident with done
//   busy                         high while a memory access is outstanding
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic [DW-1:0]   if_rdata;
    logic            if_done;

    logic            dm_req;
    logic            dm_we;
    logic [AW-1:0]   dm_addr;
    logic [DW-1:0]   dm_wdata;
    logic [DW/8-1:0] dm_wstrb;
    logic [DW-1:0]   dm_rdata;
    logic            dm_done;

    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_wstrb;
    logic            mem_ack;
    logic [DW-1:0]   mem_rdata;

    logic            err;
    logic            busy;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_done,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        output dm_rdata, dm_done,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rdata,
        output err, busy
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_done,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        input  dm_rdata, dm_done,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rdata,
        input  err, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between the instruction fetch (IF) and data
// access (DM) requesters. Requesters hold req until their done pulse; the
// memory side is a variable-latency req/ack handshake. DM has priority, but
// after STARVE_LIMIT consecutive DM grants with if_req pending, IF is forced
// to win. An access that sees no mem_ack for MAX_WAIT busy cycles is ended
// with err and zero read data.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; abandons any access in flight
//   bus    mem_port_arbiter_if.slave carrying if_*, dm_*, mem_*, err, busy
//
// Parameters
//   AW, DW        address / data width (strobe width DW/8)
//   MAX_WAIT      busy cycles without mem_ack before timeout (>= 1)
//   STARVE_LIMIT  consecutive DM grants over a pending IF before IF wins (>= 1)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_WAIT     = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // wait_cnt only needs to reach MAX_WAIT-1; starve_cnt saturates at the limit.
    localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [WW-1:0] WAIT_LAST   = WW'(MAX_WAIT - 1);
    localparam logic [SW-1:0] STARVE_FULL = SW'(STARVE_LIMIT);

    logic [0:0]      state;
    logic [WW-1:0]   wait_cnt;
    logic [SW-1:0]   starve_cnt;
    logic            owner_dm;

    logic            mem_req_r;
    logic            mem_we_r;
    logic [AW-1:0]   mem_addr_r;
    logic [DW-1:0]   mem_wdata_r;
    logic [DW/8-1:0] mem_wstrb_r;

    logic [DW-1:0]   if_rdata_r;
    logic [DW-1:0]   dm_rdata_r;
    logic            if_done_r;
    logic            dm_done_r;
    logic            err_r;

    logic            if_elig;
    logic            dm_elig;
    logic            starve_hit;
    logic            grant_if;
    logic            grant_dm;
    logic            ack;
    logic            tout;

    // A requester showing done this cycle drops req on the coming edge, so it
    // must not be granted again from the req it is still presenting.
    assign if_elig    = bus.if_req & ~if_done_r;
    assign dm_elig    = bus.dm_req & ~dm_done_r;
    assign starve_hit = (starve_cnt == STARVE_FULL);

    assign grant_if = (state == ST_IDLE) & if_elig & (~dm_elig | starve_hit);
    assign grant_dm = (state == ST_IDLE) & dm_elig & ~grant_if;

    // An ack on the final wait cycle takes precedence over the timeout.
    assign ack  = (state == ST_BUSY) & bus.mem_ack;
    assign tout = (state == ST_BUSY) & ~bus.mem_ack & (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            starve_cnt  <= '0;
            owner_dm    <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_wstrb_r <= '0;
            if_rdata_r  <= '0;
            dm_rdata_r  <= '0;
            if_done_r   <= 1'b0;
            dm_done_r   <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            if_done_r <= 1'b0;
            dm_done_r <= 1'b0;
            err_r     <= 1'b0;

            if (state == ST_IDLE) begin
                if (grant_if || grant_dm) begin
                    state       <= ST_BUSY;
                    wait_cnt    <= '0;
                    owner_dm    <= grant_dm;
                    mem_req_r   <= 1'b1;
                    mem_addr_r  <= grant_dm ? bus.dm_addr : bus.if_addr;
                    // Fetches are always reads with no byte lanes enabled.
                    mem_we_r    <= grant_dm & bus.dm_we;
                    mem_wdata_r <= grant_dm ? bus.dm_wdata : '0;
                    mem_wstrb_r <= grant_dm ? bus.dm_wstrb : '0;

                    if (grant_dm && bus.if_req) begin
                        if (!starve_hit) begin
                            starve_cnt <= starve_cnt + SW'(1);
                        end
                    end else begin
                        starve_cnt <= '0;
                    end
                end
            end else begin
                if (ack || tout) begin
                    state     <= ST_IDLE;
                    mem_req_r <= 1'b0;
                    err_r     <= tout;
                    if (owner_dm) begin
                        dm_done_r <= 1'b1;
                        // A completed write leaves the last read value in place.
                        if (tout) begin
                            dm_rdata_r <= '0;
                        end else if (!mem_we_r) begin
                            dm_rdata_r <= bus.mem_rdata;
                        end
                    end else begin
                        if_done_r  <= 1'b1;
                        if_rdata_r <= tout ? '0 : bus.mem_rdata;
                    end
                end else begin
                    wait_cnt <= wait_cnt + WW'(1);
                end
            end
        end
    end

    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_wstrb = mem_wstrb_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.dm_rdata  = dm_rdata_r;
    assign bus.if_done   = if_done_r;
    assign bus.dm_done   = dm_done_r;
    assign bus.err       = err_r;
    assign bus.busy      = (state == ST_BUSY);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter: a table of single transactions with
// hand-computed latency/data/err, plus sequences for back-to-back service,
// starvation guard and reset during an outstanding access.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW           = 32;
    localparam int DW           = 32;
    localparam int MAX_WAIT     = 15;
    localparam int STARVE_LIMIT = 4;
    localparam int NOACK        = -1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: acks ack_lat cycles after mem_req is first seen high.
    logic        auto_ack  = 1'b0;
    logic        force_ack = 1'b0;
    logic        ack_en    = 1'b0;
    int          ack_lat   = 0;
    int          lat_cnt   = 0;
    logic [31:0] rsp_data  = 32'h0;

    assign bus.mem_ack = auto_ack | force_ack;

    always @(negedge clk) begin
        if (ack_en && bus.mem_req) begin
            if (lat_cnt == ack_lat) begin
                auto_ack      <= 1'b1;
                lat_cnt       <= 0;
                bus.mem_rdata <= rsp_data;
            end else begin
                auto_ack      <= 1'b0;
                lat_cnt       <= lat_cnt + 1;
                bus.mem_rdata <= 32'hBAD0_BAD0;
            end
        end else begin
            auto_ack      <= 1'b0;
            lat_cnt       <= 0;
            bus.mem_rdata <= 32'hBAD0_BAD0;
        end
    end

    // Grant log: one entry per rising mem_req.
    logic [31:0] g_addr [128];
    logic        g_we   [128];
    int          g_cyc  [128];
    int          g_n    = 0;
    logic        mreq_q = 1'b0;

    always @(negedge clk) begin
        mreq_q <= bus.mem_req;
        if (bus.mem_req && !mreq_q && g_n < 128) begin
            g_addr[g_n] <= bus.mem_addr;
            g_we[g_n]   <= bus.mem_we;
            g_cyc[g_n]  <= cyc;
            g_n         <= g_n + 1;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;
        logic [31:0] mdata;
        int          exp_c;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt [8];

    task automatic run_vec(input vec_t v, input int idx);
        int  g0;
        bit  got;
        logic done_o, done_x;
        logic [31:0] rd;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        g0       = g_n;
        ack_en   = (v.lat != NOACK);
        ack_lat  = (v.lat != NOACK) ? v.lat : 0;
        rsp_data = v.mdata;
        if (v.dm) begin
            bus.if_req   = 1'b0;
            bus.dm_req   = 1'b1;
            bus.dm_we    = v.we;
            bus.dm_addr  = v.addr;
            bus.dm_wdata = v.wdata;
            bus.dm_wstrb = v.wstrb;
        end else begin
            // Leave DM write fields asserted to show a fetch ignores them.
            bus.dm_req   = 1'b0;
            bus.dm_we    = 1'b1;
            bus.dm_wdata = 32'hFFFF_FFFF;
            bus.dm_wstrb = 4'hF;
            bus.if_req   = 1'b1;
            bus.if_addr  = v.addr;
        end
        got = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk({tag, "_busy"},     32'(bus.busy),      32'd1);
                chk({tag, "_mem_req"},  32'(bus.mem_req),   32'd1);
                chk({tag, "_mem_addr"}, bus.mem_addr,       v.addr);
                chk({tag, "_mem_we"},   32'(bus.mem_we),    32'(v.dm & v.we));
                chk({tag, "_mem_wstrb"}, 32'(bus.mem_wstrb), v.dm ? 32'(v.wstrb) : 32'd0);
                if (v.dm && v.we) chk({tag, "_mem_wdata"}, bus.mem_wdata, v.wdata);
            end
            done_o = v.dm ? bus.dm_done  : bus.if_done;
            done_x = v.dm ? bus.if_done  : bus.dm_done;
            rd     = v.dm ? bus.dm_rdata : bus.if_rdata;
            if (done_o) begin
                got = 1;
                chk({tag, "_latency"}, c, v.exp_c);
                chk({tag, "_rdata"},   rd, v.exp_rd);
                chk({tag, "_err"},     32'(bus.err), 32'(v.exp_err));
                chk({tag, "_other_done"}, 32'(done_x), 32'd0);
                chk({tag, "_req_drop"}, 32'(bus.mem_req | bus.busy), 32'd0);
            end
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        @(negedge clk);
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        chk({tag, "_done_pulse"}, 32'(bus.if_done | bus.dm_done | bus.err), 32'd0);
        ack_en = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk({tag, "_grants"}, g_n - g0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g0, dmc, ifc;
        bit if_pend;
        logic [31:0] exp_ord [6];

        vt[0] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0,         4'h0, 0,     32'h0000_0013, 2,  32'h0000_0013, 1'b0};
        vt[1] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         4'h0, 1,     32'hCAFE_F00D, 3,  32'hCAFE_F00D, 1'b0};
        vt[2] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 2,     32'h1111_1111, 4,  32'hCAFE_F00D, 1'b0};
        vt[3] = '{1'b0, 1'b0, 32'h0000_1004, 32'h0,         4'h0, 3,     32'h00A0_0093, 5,  32'h00A0_0093, 1'b0};
        vt[4] = '{1'b1, 1'b0, 32'h0000_0204, 32'h0,         4'h0, 14,    32'h5555_AAAA, 16, 32'h5555_AAAA, 1'b0};
        vt[5] = '{1'b1, 1'b0, 32'h0000_0208, 32'h0,         4'h0, NOACK, 32'h0,         16, 32'h0,         1'b1};
        vt[6] = '{1'b0, 1'b0, 32'h0000_1008, 32'h0,         4'h0, NOACK, 32'h0,         16, 32'h0,         1'b1};
        vt[7] = '{1'b1, 1'b1, 32'h0000_010C, 32'h0000_BEEF, 4'h3, 0,     32'h2222_2222, 2,  32'h0,         1'b0};

        bus.if_req = 0; bus.if_addr = 0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0; bus.dm_wstrb = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_mem_req",  32'(bus.mem_req),  32'd0);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_dones",    32'(bus.if_done | bus.dm_done | bus.err), 32'd0);
        chk("rst_mem_we",   32'(bus.mem_we),   32'd0);
        chk("rst_mem_addr", bus.mem_addr,      32'd0);
        chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
        chk("rst_if_rdata", bus.if_rdata,      32'd0);
        chk("rst_dm_rdata", bus.dm_rdata,      32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vt[i], i);

        // Simultaneous requests: DM write first, IF granted in the dm_done cycle.
        @(negedge clk);
        g0 = g_n; dmc = -1; ifc = -1;
        ack_en = 1'b1; ack_lat = 2; rsp_data = 32'h0000_0033;
        bus.dm_we = 1'b1; bus.dm_addr = 32'h100; bus.dm_wdata = 32'hDEAD_BEEF; bus.dm_wstrb = 4'hF;
        bus.if_addr = 32'h1000;
        bus.dm_req = 1'b1; bus.if_req = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (dmc >= 0) bus.dm_req = 1'b0;
            if (ifc >= 0) bus.if_req = 1'b0;
            if (bus.dm_done && dmc < 0) dmc = c;
            if (bus.if_done && ifc < 0) begin
                ifc = c;
                chk("b2b_if_rdata", bus.if_rdata, 32'h0000_0033);
            end
        end
        #1;
        chk("b2b_dm_done_cycle", dmc, 32'd4);
        chk("b2b_if_done_cycle", ifc, 32'd8);
        chk("b2b_grants", g_n - g0, 32'd2);
        chk("b2b_first_addr", g_addr[g0], 32'h100);
        chk("b2b_first_we", 32'(g_we[g0]), 32'd1);
        chk("b2b_second_addr", g_addr[g0+1], 32'h1000);
        chk("b2b_second_we", 32'(g_we[g0+1]), 32'd0);
        chk("b2b_no_dead_cycle", g_cyc[g0+1] - g_cyc[g0], 32'd4);
        chk("b2b_dm_rdata_kept", bus.dm_rdata, 32'd0);
        ack_en = 1'b0;

        // Starvation guard. The fetch side releases if_req during each dm_done
        // cycle so it cannot take the done-cycle slot; DM then wins each fresh
        // IDLE cycle by priority until the guard forces IF through.
        @(negedge clk);
        g0 = g_n; if_pend = 1;
        ack_en = 1'b1; ack_lat = 1; rsp_data = 32'h0000_0077;
        bus.dm_we = 1'b0; bus.dm_addr = 32'h2000; bus.if_addr = 32'h1000;
        bus.dm_req = 1'b1; bus.if_req = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.if_done) if_pend = 0;
            bus.if_req = if_pend && !bus.dm_done;
        end
        bus.dm_req = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        exp_ord = '{32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h1000, 32'h2000};
        chk("starve_enough_grants", 32'(g_n - g0 >= 6), 32'd1);
        for (int i = 0; i < 6; i++) chk($sformatf("starve_order%0d", i), g_addr[g0+i], exp_ord[i]);
        chk("starve_if_rdata", bus.if_rdata, 32'h0000_0077);
        ack_en = 1'b0;

        // Reset during BUSY, then a stale ack after release.
        @(negedge clk);
        bus.dm_we = 1'b0; bus.dm_addr = 32'h300; bus.dm_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstb_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstb_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rstb_busy",    32'(bus.busy),    32'd0);
        bus.dm_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        force_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rstb_idle%0d", c),
                32'({bus.if_done, bus.dm_done, bus.err, bus.busy, bus.mem_req}), 32'd0);
        end
        force_ack = 1'b0;
        chk("rstb_if_rdata", bus.if_rdata, 32'd0);
        chk("rstb_dm_rdata", bus.dm_rdata, 32'd0);
        run_vec(vt[0], 8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
